// File: rtl/xrbus_boundary_sched_if.sv
// rtl/xrbus_boundary_sched_if.sv - requester, tagger and result bus of the boundary scheduler
interface xrbus_boundary_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 4096,
  parameter int ID_W    = 3
) ();
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*16-1:0]      req_boundary_id;
  logic [NUM_REQ*8-1:0]       req_boundary_type;
  logic [NUM_REQ*FRAME_W-1:0] req_frame;

  logic                       tag_valid;
  logic [15:0]                tag_boundary_id;
  logic [7:0]                 tag_boundary_type;
  logic [FRAME_W-1:0]         tag_frame;
  logic [15:0]                tag_src_boundary;
  logic [15:0]                tag_dst_boundary;
  logic [31:0]                tag_policy_mask;
  logic [FRAME_W-1:0]         tag_tagged_frame;

  logic                       out_valid;
  logic                       out_ready;
  logic [15:0]                out_src_boundary;
  logic [15:0]                out_dst_boundary;
  logic [31:0]                out_policy_mask;
  logic [FRAME_W-1:0]         out_frame;
  logic [ID_W-1:0]            out_req_id;

  modport master (
    input  req_valid, req_boundary_id, req_boundary_type, req_frame,
    input  tag_src_boundary, tag_dst_boundary, tag_policy_mask, tag_tagged_frame,
    input  out_ready,
    output req_ready,
    output tag_valid, tag_boundary_id, tag_boundary_type, tag_frame,
    output out_valid, out_src_boundary, out_dst_boundary, out_policy_mask, out_frame, out_req_id
  );

  modport slave (
    output req_valid, req_boundary_id, req_boundary_type, req_frame,
    output tag_src_boundary, tag_dst_boundary, tag_policy_mask, tag_tagged_frame,
    output out_ready,
    input  req_ready,
    input  tag_valid, tag_boundary_id, tag_boundary_type, tag_frame,
    input  out_valid, out_src_boundary, out_dst_boundary, out_policy_mask, out_frame, out_req_id
  );
endinterface

// File: rtl/xrbus_boundary_sched.sv
// rtl/xrbus_boundary_sched.sv - round-robin sharing of one boundary tagger; XRBUS_SCHED_POLICY_CHECK_EN enables policy drops
module xrbus_boundary_sched #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 4096,
  parameter int ID_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xrbus_boundary_sched_if.master bus,
  output logic                   busy,
  output logic                   drop_err,
  output logic [7:0]             drop_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t             state, state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    req_idx;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_found;
  logic [15:0]        grant_id;
  logic [7:0]         grant_type;
  logic [FRAME_W-1:0] grant_frame;
  logic [NUM_REQ-1:0] ready_vec;
  logic               policy_drop;

  // Two passes: indices above rr_ptr first, then wrap to the low indices.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[i] && (ID_W'(i) > rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[i] && (ID_W'(i) <= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    grant_id    = '0;
    grant_type  = '0;
    grant_frame = '0;
    ready_vec   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        grant_id    = bus.req_boundary_id[16*i +: 16];
        grant_type  = bus.req_boundary_type[8*i +: 8];
        grant_frame = bus.req_frame[FRAME_W*i +: FRAME_W];
        ready_vec[i] = rst_n && (state == IDLE) && grant_found;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign busy          = (state != IDLE);

`ifdef XRBUS_SCHED_POLICY_CHECK_EN
  assign policy_drop = (bus.tag_policy_mask == 32'h0);
`else
  assign policy_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = policy_drop ? IDLE : HOLD;
      HOLD:    if (bus.out_valid && bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr                <= ID_W'(NUM_REQ - 1);
      req_idx               <= '0;
      bus.tag_valid         <= 1'b0;
      bus.tag_boundary_id   <= '0;
      bus.tag_boundary_type <= '0;
      bus.tag_frame         <= '0;
      bus.out_valid         <= 1'b0;
      bus.out_src_boundary  <= '0;
      bus.out_dst_boundary  <= '0;
      bus.out_policy_mask   <= '0;
      bus.out_frame         <= '0;
      bus.out_req_id        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            bus.tag_boundary_id   <= grant_id;
            bus.tag_boundary_type <= grant_type;
            bus.tag_frame         <= grant_frame;
            req_idx               <= grant_idx;
            rr_ptr                <= grant_idx;
            bus.tag_valid         <= 1'b1;
          end
        end
        ISSUE: bus.tag_valid <= 1'b0;
        CAPTURE: begin
          // The tagger registered its result on the message_valid edge.
          if (!policy_drop) begin
            bus.out_src_boundary <= bus.tag_src_boundary;
            bus.out_dst_boundary <= bus.tag_dst_boundary;
            bus.out_policy_mask  <= bus.tag_policy_mask;
            bus.out_frame        <= bus.tag_tagged_frame;
            bus.out_req_id       <= req_idx;
            bus.out_valid        <= 1'b1;
          end
        end
        HOLD: if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef XRBUS_SCHED_POLICY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_err   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      drop_err <= (state == CAPTURE) && policy_drop;
      if ((state == CAPTURE) && policy_drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign drop_err   = 1'b0;
  assign drop_count = 8'h00;
`endif

endmodule
